spi_slave: RTL and testbench



---
 rtl/spi_slave_pkg.sv | 29 ++
 rtl/spi_slave.sv | 123 ++++++++++++
 tb/tb_spi_slave.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared widths, FSM states and command encodings for spi_slave
package spi_slave_pkg;

  localparam int RX_W = 10;
  localparam int TX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  typedef enum logic [1:0] {
    PH_RX,
    PH_WAIT_TX,
    PH_TX
  } rd_phase_t;

  // Carried in rx_data[9:8]; the slave passes these through without decoding
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

endpackage

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave: 10-bit frame deserialiser with 8-bit read-back serialiser
module spi_slave
  import spi_slave_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            MOSI,
  output logic            MISO,
  input  logic            SS_n,
  output logic [RX_W-1:0] rx_data,
  output logic            rx_valid,
  input  logic [TX_W-1:0] tx_data,
  input  logic            tx_valid
);

  localparam logic [3:0] LAST_RX_BIT = 4'(RX_W - 1);
  localparam logic [2:0] LAST_TX_BIT = 3'(TX_W - 1);

  state_t          state;
  rd_phase_t       phase;
  logic            rd_addr_seen;
  logic [RX_W-1:0] rx_sr;
  logic [3:0]      rx_cnt;
  logic [TX_W-1:0] tx_sr;
  logic [2:0]      tx_cnt;
  logic            rx_phase;

  assign rx_phase = (state == WRITE) || (state == READ_ADD) ||
                    ((state == READ_DATA) && (phase == PH_RX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= PH_RX;
      rd_addr_seen <= 1'b0;
      rx_sr        <= '0;
      rx_cnt       <= '0;
      tx_sr        <= '0;
      tx_cnt       <= '0;
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // A frame whose last bit lands on the SS_n release edge still completes
      if (rx_phase && rx_cnt == LAST_RX_BIT) begin
        rx_data  <= {rx_sr[RX_W-2:0], MOSI};
        rx_valid <= 1'b1;
        rx_cnt   <= '0;
        if (state == READ_ADD) rd_addr_seen <= 1'b1;
        if (SS_n) begin
          state  <= IDLE;
          phase  <= PH_RX;
          tx_sr  <= '0;
          tx_cnt <= '0;
          MISO   <= 1'b0;
        end else if (state == READ_DATA) begin
          phase <= PH_WAIT_TX;
        end else begin
          state <= CHK_CMD;
        end
      end else if (SS_n) begin
        state  <= IDLE;
        phase  <= PH_RX;
        rx_cnt <= '0;
        tx_sr  <= '0;
        tx_cnt <= '0;
        MISO   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= CHK_CMD;
            phase <= PH_RX;
          end
          CHK_CMD: begin
            rx_cnt <= '0;
            phase  <= PH_RX;
            if (!MOSI)            state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA;
            else                  state <= READ_ADD;
          end
          WRITE, READ_ADD: begin
            rx_sr  <= {rx_sr[RX_W-2:0], MOSI};
            rx_cnt <= rx_cnt + 4'd1;
          end
          READ_DATA: begin
            case (phase)
              PH_RX: begin
                rx_sr  <= {rx_sr[RX_W-2:0], MOSI};
                rx_cnt <= rx_cnt + 4'd1;
              end
              PH_WAIT_TX: begin
                if (tx_valid) begin
                  MISO   <= tx_data[TX_W-1];
                  tx_sr  <= {tx_data[TX_W-2:0], 1'b0};
                  tx_cnt <= '0;
                  phase  <= PH_TX;
                end
              end
              PH_TX: begin
                if (tx_cnt == LAST_TX_BIT) begin
                  MISO         <= 1'b0;
                  rd_addr_seen <= 1'b0;
                  tx_sr        <= '0;
                  tx_cnt       <= '0;
                  phase        <= PH_RX;
                  state        <= CHK_CMD;
                end else begin
                  MISO   <= tx_sr[TX_W-1];
                  tx_sr  <= {tx_sr[TX_W-2:0], 1'b0};
                  tx_cnt <= tx_cnt + 3'd1;
                end
              end
              default: phase <= PH_RX;
            endcase
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed, table-driven self-checking bench for spi_slave
module tb_spi_slave;
  import spi_slave_pkg::*;

  logic       clk;
  logic       rst;
  logic       MOSI;
  logic       MISO;
  logic       SS_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int consec = 0;
  logic prev_v = 1'b0;

  spi_slave dut (
    .clk(clk), .rst(rst), .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid && prev_v) consec++;
    prev_v = rx_valid;
  end

  typedef struct {
    logic [9:0] frame;
    logic [9:0] exp_data;
    logic [1:0] exp_cmd;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic ss, input logic mosi);
    @(negedge clk);
    SS_n = ss;
    MOSI = mosi;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic dir, input logic [9:0] f, output int early);
    early = 0;
    step(1'b0, dir);
    if (rx_valid) early++;
    for (int i = 9; i >= 0; i--) begin
      step(1'b0, f[i]);
      if (i != 0 && rx_valid) early++;
    end
  endtask

  initial begin
    int early;
    int cnt;
    int t1;
    int t2;
    logic [7:0] exp_tx;

    vecs[0] = '{10'h0C3, 10'h0C3, 2'b00};
    vecs[1] = '{10'h3FF, 10'h3FF, 2'b11};
    vecs[2] = '{10'h2AA, 10'h2AA, 2'b10};
    vecs[3] = '{10'h155, 10'h155, 2'b01};
    vecs[4] = '{10'h200, 10'h200, 2'b10};

    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_miso", 32'(MISO), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_rd_addr_seen", 32'(dut.rd_addr_seen), 32'd0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Write frame 0C3, MOSI=1 during the IDLE edge must be ignored
    step(1'b0, 1'b1);
    send_frame(1'b0, 10'h0C3, early);
    chk("wr_rx_valid", 32'(rx_valid), 32'd1);
    chk("wr_rx_data", 32'(rx_data), 32'h0C3);
    chk("wr_no_early", 32'(early), 32'd0);
    step(1'b1, 1'b0);
    chk("wr_strobe_one_cycle", 32'(rx_valid), 32'd0);
    chk("wr_state_idle", 32'(dut.state), 32'(IDLE));
    step(1'b1, 1'b0);
    chk("wr_no_extra_strobe", 32'(rx_valid), 32'd0);

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'(i));
      send_frame(1'b0, vecs[i].frame, early);
      chk($sformatf("tbl%0d_valid", i), 32'(rx_valid), 32'd1);
      chk($sformatf("tbl%0d_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
      chk($sformatf("tbl%0d_cmd", i), 32'(rx_data[9:8]), 32'(vecs[i].exp_cmd));
      chk($sformatf("tbl%0d_early", i), 32'(early), 32'd0);
      step(1'b1, 1'b0);
    end

    // Abort after 5 data bits
    cnt = 0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      if (rx_valid) cnt++;
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1);
      if (rx_valid) cnt++;
    end
    chk("abort_no_strobe", 32'(cnt), 32'd0);
    chk("abort_rx_data_kept", 32'(rx_data), 32'h200);
    step(1'b0, 1'b0);
    send_frame(1'b0, 10'h0F0, early);
    chk("post_abort_valid", 32'(rx_valid), 32'd1);
    chk("post_abort_data", 32'(rx_data), 32'h0F0);

    // Back-to-back writes without SS_n toggle
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    send_frame(1'b0, 10'h001, early);
    chk("b2b0_valid", 32'(rx_valid), 32'd1);
    chk("b2b0_data", 32'(rx_data), 32'h001);
    t1 = cyc;
    send_frame(1'b0, 10'h1FF, early);
    chk("b2b1_valid", 32'(rx_valid), 32'd1);
    chk("b2b1_data", 32'(rx_data), 32'h1FF);
    chk("b2b1_early", 32'(early), 32'd0);
    t2 = cyc;
    chk("b2b_spacing", 32'(t2 - t1), 32'd11);

    // SS_n released on the edge that samples the 10th bit
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    begin
      logic [9:0] f;
      f = 10'h2C3;
      for (int i = 9; i >= 1; i--) step(1'b0, f[i]);
      step(1'b1, f[0]);
    end
    chk("ssrise_valid", 32'(rx_valid), 32'd1);
    chk("ssrise_data", 32'(rx_data), 32'h2C3);
    chk("ssrise_state", 32'(dut.state), 32'(IDLE));
    step(1'b1, 1'b0);
    chk("ssrise_single", 32'(rx_valid), 32'd0);

    // Read sequence; tx_valid held high during the address frame must be ignored
    step(1'b0, 1'b0);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    send_frame(1'b1, 10'h2A5, early);
    chk("rda_valid", 32'(rx_valid), 32'd1);
    chk("rda_data", 32'(rx_data), 32'h2A5);
    chk("rda_seen", 32'(dut.rd_addr_seen), 32'd1);
    chk("rda_miso_quiet", 32'(MISO), 32'd0);
    tx_valid = 1'b0;
    send_frame(1'b1, 10'h300, early);
    chk("rdd_valid", 32'(rx_valid), 32'd1);
    chk("rdd_data", 32'(rx_data), 32'h300);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1);
      if (MISO || rx_valid) cnt++;
    end
    chk("stall_quiet", 32'(cnt), 32'd0);
    chk("stall_state", 32'(dut.state), 32'(READ_DATA));
    tx_data = 8'hB6;
    tx_valid = 1'b1;
    exp_tx = 8'hB6;
    step(1'b0, 1'b0);
    tx_valid = 1'b0;
    chk("tx_bit7", 32'(MISO), 32'(exp_tx[7]));
    for (int i = 6; i >= 0; i--) begin
      step(1'b0, 1'b0);
      chk($sformatf("tx_bit%0d", i), 32'(MISO), 32'(exp_tx[i]));
    end
    step(1'b0, 1'b0);
    chk("tx_done_miso", 32'(MISO), 32'd0);
    chk("tx_done_seen", 32'(dut.rd_addr_seen), 32'd0);
    chk("tx_done_state", 32'(dut.state), 32'(CHK_CMD));

    // Asynchronous reset in the middle of a read-back
    send_frame(1'b1, 10'h2A5, early);
    send_frame(1'b1, 10'h3C0, early);
    chk("rst_pre_data", 32'(rx_data), 32'h3C0);
    tx_data = 8'h80;
    tx_valid = 1'b1;
    step(1'b0, 1'b0);
    tx_valid = 1'b0;
    chk("rst_pre_miso", 32'(MISO), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_seen", 32'(dut.rd_addr_seen), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    SS_n = 1'b1;

    chk("rx_valid_never_consecutive", 32'(consec), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
